imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the single-cycle-to-pipelined datapath migration.
- Takes a 26-bit instruction immediate field plus a 3-bit format select and produces an XLEN-wide extended immediate.
- Two register stages with valid/ready handshakes on both sides, so decode stalls propagate cleanly.
- Adds a MOVZ-style IW halfword shift, illegal-format flagging and a saturating error counter.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- CNT_W, 8, width of the illegal-format counter.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept input this cycle.
- imm26  in  26  raw immediate field, instruction bits [25:0].
- ctrl  in  3  format select.
- out_valid  out  1  imm_out/err valid.
- out_ready  in  1  consumer accepts output this cycle.
- imm_out  out  XLEN  extended immediate.
- err  out  1  illegal ctrl for this beat.
- err_cnt  out  CNT_W  count of accepted illegal beats, saturating.

Behaviour:
- Reset: async assert, sync deassert.
  - s1_valid=0, s2_valid=0, imm_out=0, err=0, err_cnt=0, out_valid=0.
  - in_ready=1 after reset.
  - Reset mid-transfer discards all in-flight beats.
- Format decode, stage 1; field extracted and registered with its extension type:
  - 000 I: imm26[21:10], 12 bits, zero-extend.
  - 001 D: imm26[20:12], 9 bits, sign-extend from bit 20.
  - 010 B: imm26[25:0], 26 bits, sign-extend from bit 25.
  - 011 CB: imm26[23:5], 19 bits, sign-extend from bit 23.
  - 100 IW: imm26[20:5], 16 bits, zero-extend, then shift left by 16*imm26[22:21].
  - 101..111: illegal; value 0, err=1.
- Stage 2: performs extension and shift to XLEN.
  - Result is truncated modulo 2^XLEN. With XLEN=32, IW with hw=2 or 3 yields 0.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Transfer when valid & ready on the same edge.
  - Output holds imm_out and err stable while out_valid & !out_ready.
- Latency: 2 cycles from input accept to out_valid with out_ready held 1. Throughput is 1 beat per cycle.
- Buffering: holds at most 2 beats. With out_ready=0 and both stages full, in_ready=0.
- Bubbles: an empty stage never blocks; in_valid=0 creates a bubble that propagates.
- err_cnt:
  - Increments on the stage-2 output transfer (out_valid & out_ready) of a beat with err=1.
  - Saturates at all-ones; no wrap.
- Inputs imm26/ctrl are sampled only on the accept edge and ignored otherwise.

Optional Feature:
- Macro IMMGEN_BRSHIFT_EN.
- Defined: B and CB results are shifted left 2 after sign extension (word offset to byte offset), truncated to XLEN. Other formats are unchanged.
- Undefined: B and CB results are the sign-extended word offset only.

Test Plan:
- XLEN=64, out_ready=1, back-to-back I(imm26[21:10]=12'hFFF), D(imm26[20:12]=9'h100), CB(imm26[23:5]=19'h7FFFF) -> after 2 cycles, one per cycle: 0x0000000000000FFF, 0xFFFFFFFFFFFFFF00, 0xFFFFFFFFFFFFFFFF (0xFFFFFFFFFFFFFFFC with IMMGEN_BRSHIFT_EN); err=0 each.
- IW, imm26[20:5]=16'hBEEF, hw=2 -> 0x0000BEEF00000000. Same with XLEN=32 -> 0x00000000.
- ctrl=3'b110 for 3 beats accepted and delivered -> err=1 and imm_out=0 on each; err_cnt=3. With CNT_W=2 and 5 illegal beats -> err_cnt sticks at 3.
- out_ready=0 while feeding 3 beats -> 2 accepted, in_ready=0 on the third, imm_out held stable. Raise out_ready -> all 3 emerge in order, none lost or duplicated.
- B with imm26=26'h2000000 -> 0xFFFFFFFFFE000000. Assert RST_N=0 asynchronously mid-stall -> out_valid, err_cnt, imm_out all 0 immediately. After release, in_ready=1 and the old beat is not output.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Two-stage valid/ready immediate generator. Stage 1 decodes the
//            format and registers the raw field. Stage 2 extends and shifts it
//            to XLEN, flags illegal formats and counts them (saturating).
//            Optional macro IMMGEN_BRSHIFT_EN: B/CB results become byte
//            offsets (shift left 2).
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [25:0]      imm26,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0]       c_FMT_I   = 3'b000;
  localparam logic [2:0]       c_FMT_D   = 3'b001;
  localparam logic [2:0]       c_FMT_B   = 3'b010;
  localparam logic [2:0]       c_FMT_CB  = 3'b011;
  localparam logic [2:0]       c_FMT_IW  = 3'b100;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Handshake
  logic w_s2_adv;
  logic w_s1_adv;

  // Stage 1 registers
  logic        r_s1_valid;
  logic [2:0]  r_s1_fmt;
  logic [25:0] r_s1_field;
  logic [1:0]  r_s1_hw;
  logic        r_s1_err;

  // Stage 1 decode
  logic [25:0] w_field;
  logic        w_err;

  // Stage 2 datapath, always computed at 64 bits then truncated
  logic [63:0]     w_ext;
  logic [63:0]     w_res;
  logic [XLEN-1:0] w_imm;

  // Output registers
  logic             r_out_valid;
  logic [XLEN-1:0]  r_imm;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    w_field = '0;
    w_err   = 1'b0;
    case (ctrl)
      c_FMT_I:  w_field = {14'b0, imm26[21:10]};
      c_FMT_D:  w_field = {17'b0, imm26[20:12]};
      c_FMT_B:  w_field = imm26;
      c_FMT_CB: w_field = {7'b0, imm26[23:5]};
      c_FMT_IW: w_field = {10'b0, imm26[20:5]};
      default:  w_err   = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_valid <= 1'b0;
      r_s1_fmt   <= '0;
      r_s1_field <= '0;
      r_s1_hw    <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_fmt   <= ctrl;
        r_s1_field <= w_field;
        r_s1_hw    <= imm26[22:21];
        r_s1_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_ext = '0;
    case (r_s1_fmt)
      c_FMT_I:  w_ext = {52'b0, r_s1_field[11:0]};
      c_FMT_D:  w_ext = {{55{r_s1_field[8]}}, r_s1_field[8:0]};
      c_FMT_B:  w_ext = {{38{r_s1_field[25]}}, r_s1_field};
      c_FMT_CB: w_ext = {{45{r_s1_field[18]}}, r_s1_field[18:0]};
      c_FMT_IW: w_ext = {48'b0, r_s1_field[15:0]} << {r_s1_hw, 4'b0000};
      default:  w_ext = '0;
    endcase
  end

`ifdef IMMGEN_BRSHIFT_EN
  // Branch displacements are word offsets; convert to byte offsets
  assign w_res = ((r_s1_fmt == c_FMT_B) || (r_s1_fmt == c_FMT_CB)) ? (w_ext << 2) : w_ext;
`else
  assign w_res = w_ext;
`endif

  generate
    if (XLEN == 64) begin : g_xlen_full
      assign w_imm = w_res;
    end else begin : g_xlen_narrow
      logic w_unused_hi;
      assign w_imm       = w_res[XLEN-1:0];
      assign w_unused_hi = &{1'b0, w_res[63:XLEN]};
    end
  endgenerate

  // Data only loads with a real beat so a held output never changes under stall
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_err       <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_imm <= w_imm;
        r_err <= r_s1_err;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err_cnt <= '0;
    end else if (r_out_valid && out_ready && r_err && (r_err_cnt != c_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + c_CNT_ONE;
    end
  end

  assign out_valid = r_out_valid;
  assign imm_out   = r_imm;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Scoreboard bench for imm_gen_pipe; drives a 64-bit/8-bit-counter
//            instance and a 32-bit/2-bit-counter instance in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic [25:0] imm26;
  logic [2:0]  ctrl;
  logic        out_ready;

  logic        in_ready,  out_valid,  err;
  logic [63:0] imm_out;
  logic [7:0]  err_cnt;
  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm_out32;
  logic [1:0]  err_cnt32;

  always #5 CLK = ~CLK;

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .imm26(imm26), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .err(err), .err_cnt(err_cnt)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_dut32 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready32),
    .imm26(imm26), .ctrl(ctrl), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_out(imm_out32), .err(err32), .err_cnt(err_cnt32)
  );

`ifdef IMMGEN_BRSHIFT_EN
  localparam logic [63:0] c_CB_ONES = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] c_B_NEG   = 64'hFFFF_FFFF_F800_0000;
  localparam logic [63:0] c_B_POS   = 64'h0000_0000_0000_048C;
`else
  localparam logic [63:0] c_CB_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_B_NEG   = 64'hFFFF_FFFF_FE00_0000;
  localparam logic [63:0] c_B_POS   = 64'h0000_0000_0000_0123;
`endif

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt64 = 0;
  int   m_cnt32 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every delivered beat against the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      m_cnt64 = 0;
      m_cnt32 = 0;
    end else begin
      chk("err_cnt64", {56'b0, err_cnt}, m_cnt64);
      chk("err_cnt32", {62'b0, err_cnt32}, m_cnt32);
      chk("out_valid32", {63'b0, out_valid32}, {63'b0, out_valid});
      chk("in_ready32", {63'b0, in_ready32}, {63'b0, in_ready});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got imm %h with empty scoreboard", imm_out);
        end else begin
          e = sb_q.pop_front();
          chk("imm_out64", imm_out, e.imm);
          chk("err64", {63'b0, err}, {63'b0, e.err});
          chk("imm_out32", {32'b0, imm_out32}, {32'b0, e.imm[31:0]});
          chk("err32", {63'b0, err32}, {63'b0, e.err});
          if (e.err) begin
            if (m_cnt64 < 255) m_cnt64++;
            if (m_cnt32 < 3)   m_cnt32++;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    imm26    = '1;
    ctrl     = 3'b111;
  endtask

  task automatic drive(input logic [25:0] imm, input logic [2:0] c);
    in_valid = 1'b1;
    imm26    = imm;
    ctrl     = c;
  endtask

  task automatic wait_accept(input logic [63:0] e, input logic ee);
    bit   acc = 1'b0;
    int   n   = 0;
    exp_t x;
    while (!acc && n < 50) begin
      @(negedge CLK);
      acc = in_ready;
      if (acc) begin
        x.imm = e;
        x.err = ee;
        sb_q.push_back(x);
      end
      @(posedge CLK);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send(input logic [25:0] imm, input logic [2:0] c,
                      input logic [63:0] e, input logic ee);
    drive(imm, c);
    wait_accept(e, ee);
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (sb_q.size() > 0 && n < 100) begin
      cycles(1);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", sb_q.size());
    end
    cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N     = 1'b0;
    out_ready = 1'b1;
    idle();
    cycles(2);
    @(negedge CLK);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_imm_out", imm_out, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_err_cnt", {56'b0, err_cnt}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cycles(1);

    // Back-to-back I, D, CB with latency probe
    send(26'h03F_FC00, 3'b000, 64'h0000_0000_0000_0FFF, 1'b0);
    chk("latency_one_cycle", {63'b0, out_valid}, 64'd0);
    send(26'h010_0000, 3'b001, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    chk("latency_two_cycles", {63'b0, out_valid}, 64'd1);
    send(26'h0FF_FFE0, 3'b011, c_CB_ONES, 1'b0);
    send(26'h3FF_FFFF, 3'b000, 64'h0000_0000_0000_0FFF, 1'b0);
    send(26'h20F_F123, 3'b001, 64'h0000_0000_0000_00FF, 1'b0);
    send(26'h000_0123, 3'b010, c_B_POS, 1'b0);
    send(26'h057_DDE0, 3'b100, 64'h0000_BEEF_0000_0000, 1'b0);
    send(26'h037_DDE0, 3'b100, 64'h0000_0000_BEEF_0000, 1'b0);
    send(26'h017_DDE0, 3'b100, 64'h0000_0000_0000_BEEF, 1'b0);
    send(26'h077_DDE0, 3'b100, 64'hBEEF_0000_0000_0000, 1'b0);
    drain();

    // Illegal formats and counter saturation on the 2-bit instance
    repeat (3) send(26'h2AA_AAAA, 3'b110, 64'd0, 1'b1);
    drain();
    chk("err_cnt_three", {56'b0, err_cnt}, 64'd3);
    send(26'h155_5555, 3'b101, 64'd0, 1'b1);
    send(26'h3FF_FFFF, 3'b111, 64'd0, 1'b1);
    drain();
    chk("err_cnt_five", {56'b0, err_cnt}, 64'd5);
    chk("err_cnt32_sat", {62'b0, err_cnt32}, 64'd3);

    // Backpressure: two beats buffered, third refused, output held
    out_ready = 1'b0;
    send(26'h03F_FC00, 3'b000, 64'h0000_0000_0000_0FFF, 1'b0);
    send(26'h010_0000, 3'b001, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    drive(26'h037_DDE0, 3'b100);
    repeat (3) begin
      @(negedge CLK);
      chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_imm_hold", imm_out, 64'h0000_0000_0000_0FFF);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    wait_accept(64'h0000_0000_BEEF_0000, 1'b0);
    drain();

    // Negative B, then asynchronous reset during a stall
    send(26'h200_0000, 3'b010, c_B_NEG, 1'b0);
    drain();
    out_ready = 1'b0;
    send(26'h200_0000, 3'b010, c_B_NEG, 1'b0);
    send(26'h03F_FC00, 3'b000, 64'h0000_0000_0000_0FFF, 1'b0);
    idle();
    cycles(2);
    chk("pre_rst_imm", imm_out, c_B_NEG);
    chk("pre_rst_cnt", {56'b0, err_cnt}, 64'd5);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    sb_q.delete();
    chk("async_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("async_rst_err_cnt", {56'b0, err_cnt}, 64'd0);
    chk("async_rst_imm_out", imm_out, 64'd0);
    chk("async_rst_imm_out32", {32'b0, imm_out32}, 64'd0);
    cycles(2);
    RST_N     = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    repeat (4) begin
      cycles(1);
      chk("post_rst_no_out", {63'b0, out_valid}, 64'd0);
    end
    send(26'h000_0123, 3'b010, c_B_POS, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
